// File: rtl/booths_div_if.sv
// Handshake and data bundle between the ALU sequencer and the sequential divider.
// The master drives the request; the slave (the divider) returns the packed result and status.
interface booths_div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] C;
  logic               busy;
  logic               done;
  logic               dbz;

  modport master (output start, A, B, input  C, busy, done, dbz);
  modport slave  (input  start, A, B, output C, busy, done, dbz);
endinterface

// File: rtl/booths_div.sv
// Sequential signed divider: non-restoring, one quotient bit per cycle on magnitudes,
// sign fix-up at the end, result packed as {remainder, quotient} for HI/LO writeback.
module booths_div #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  booths_div_if.slave  dif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH:0]     r_q, r_d;        // partial remainder, two's complement, one guard bit
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;        // |B|
  logic               asign_q, asign_d;
  logic               qsign_q, qsign_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] c_q, c_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     b_ext, r_sh, r_step;
  logic [WIDTH-1:0]   r_fix, quot, rem;

  assign abs_a = dif.A[WIDTH-1] ? (~dif.A + 1'b1) : dif.A;
  assign abs_b = dif.B[WIDTH-1] ? (~dif.B + 1'b1) : dif.B;

  // The shift keeps R's sign because |R| never exceeds |B| <= 2^(WIDTH-1).
  assign b_ext  = {1'b0, b_q};
  assign r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign r_step = r_sh[WIDTH] ? (r_sh + b_ext) : (r_sh - b_ext);

  // After the restore the remainder is non-negative and below |B|, so the low bits suffice.
  assign r_fix = r_q[WIDTH] ? (r_q[WIDTH-1:0] + b_q) : r_q[WIDTH-1:0];
  assign quot  = qsign_q ? (~q_q + 1'b1) : q_q;
  assign rem   = asign_q ? (~r_fix + 1'b1) : r_fix;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    asign_d = asign_q;
    qsign_d = qsign_q;
    dbz_d   = dbz_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (dif.start) begin
          b_d     = abs_b;
          asign_d = dif.A[WIDTH-1];
          qsign_d = dif.A[WIDTH-1] ^ dif.B[WIDTH-1];
          count_d = '0;
          if (dif.B == '0) begin
            c_d     = {dif.A, {WIDTH{1'b1}}};
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            r_d     = '0;
            q_d     = abs_a;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        r_d     = r_step;
        q_d     = {q_q[WIDTH-2:0], ~r_step[WIDTH]};
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        c_d     = {rem, quot};
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      asign_q <= 1'b0;
      qsign_q <= 1'b0;
      dbz_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      asign_q <= asign_d;
      qsign_q <= qsign_d;
      dbz_q   <= dbz_d;
      c_q     <= c_d;
    end
  end

  assign dif.C    = c_q;
  assign dif.busy = (state_q != S_IDLE);
  assign dif.done = (state_q == S_DONE);
  assign dif.dbz  = dbz_q;
endmodule
